dht11_data_receiver: RTL and testbench

Downstream stage of the DHT11 start/handshake module. Armed by that module's confirm-to-receiver strobe, it samples the single-wire data line and decodes the 40-bit DHT11 frame by measuring high-pulse widths. It then verifies the checksum and publishes humidity and temperature bytes with a one-cycle valid strobe. The timebase is the same 1 MHz clk as the start module (1 cycle = 1 us).

---
 rtl/dht11_data_receiver.sv | 166 ++++++++++++++++
 tb/tb_dht11_data_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dht11_data_receiver.sv
// rtl/dht11_data_receiver.sv - DHT11 40-bit frame decoder (pulse-width bits, checksum, timeout)
// Optional build macro DHT_SYNC_EN adds a 2-flop synchronizer ahead of the line sampler.
module dht11_data_receiver #(
    parameter int BIT_THRESHOLD = 40,
    parameter int TIMEOUT       = 200,
    parameter int NUM_BITS      = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dht_in,
    output logic       busy,
    output logic       data_valid,
    output logic       checksum_err,
    output logic       timeout_err,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        MEAS_LOW,
        MEAS_HIGH,
        CHECK
    } state_t;

    localparam logic [7:0] TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [5:0] LAST_BIT   = 6'(NUM_BITS);
    localparam logic [8:0] THRESH_C   = 9'(BIT_THRESHOLD);

    state_t      state;
    logic [7:0]  count;
    logic [5:0]  bit_cnt;
    logic [39:0] shreg;
    logic        line_in;
    logic        s;
    logic        s_q;

`ifdef DHT_SYNC_EN
    logic sync_a;
    logic sync_b;

    // Reset to the idle-high level so release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= dht_in;
            sync_b <= sync_a;
        end
    end
    assign line_in = sync_b;
`else
    assign line_in = dht_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s   <= 1'b1;
            s_q <= 1'b1;
        end else begin
            s   <= line_in;
            s_q <= s;
        end
    end

    logic       fall;
    logic       rise;
    logic [7:0] count_inc;
    logic       bit_val;
    logic [7:0] sum;

    assign fall      = s_q & ~s;
    assign rise      = ~s_q & s;
    assign count_inc = (count == 8'hFF) ? count : count + 8'd1;
    // The edge-detect cycle of the rising edge is itself a high cycle, hence the +1.
    assign bit_val   = ({1'b0, count} + 9'd1) > THRESH_C;
    assign sum       = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 8'd0;
            bit_cnt      <= 6'd0;
            shreg        <= 40'd0;
            busy         <= 1'b0;
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            hum_int      <= 8'd0;
            hum_dec      <= 8'd0;
            temp_int     <= 8'd0;
            temp_dec     <= 8'd0;
        end else begin
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    count <= 8'd0;
                    if (start) begin
                        state   <= WAIT_LOW;
                        busy    <= 1'b1;
                        bit_cnt <= 6'd0;
                        shreg   <= 40'd0;
                    end
                end
                WAIT_LOW, MEAS_LOW: begin
                    if (count == TIMEOUT_C) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        count       <= 8'd0;
                    end else if (state == WAIT_LOW && fall) begin
                        state <= MEAS_LOW;
                        count <= 8'd0;
                    end else if (state == MEAS_LOW && rise) begin
                        state <= MEAS_HIGH;
                        count <= 8'd0;
                    end else begin
                        count <= count_inc;
                    end
                end
                MEAS_HIGH: begin
                    if (count == TIMEOUT_C) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        count       <= 8'd0;
                    end else if (fall) begin
                        shreg   <= {shreg[38:0], bit_val};
                        bit_cnt <= bit_cnt + 6'd1;
                        count   <= 8'd0;
                        state   <= (bit_cnt + 6'd1 == LAST_BIT) ? CHECK : MEAS_LOW;
                    end else if (s) begin
                        count <= count_inc;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= 8'd0;
                    if (sum == shreg[7:0]) begin
                        hum_int    <= shreg[39:32];
                        hum_dec    <= shreg[31:24];
                        temp_int   <= shreg[23:16];
                        temp_dec   <= shreg[15:8];
                        data_valid <= 1'b1;
                    end else begin
                        checksum_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_data_receiver.sv
// tb/tb_dht11_data_receiver.sv - randomized frame bench with behavioural decode/checksum model
module tb_dht11_data_receiver;

    localparam int BIT_THRESHOLD = 40;
    localparam int TIMEOUT       = 200;
`ifdef DHT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       dht_in = 1'b1;
    logic       busy;
    logic       data_valid;
    logic       checksum_err;
    logic       timeout_err;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;

    int cyc     = 0;
    int n_cmp   = 0;
    int n_bad   = 0;
    int dv_seen = 0;
    int ce_seen = 0;
    int te_seen = 0;

    // Model state: busy window, the single pending frame outcome, and the held data bytes.
    int          busy_from = -1;
    int          ev_cycle  = -1;
    int          ev_kind   = 0;
    logic [31:0] ev_data   = 32'd0;
    logic [31:0] m_data    = 32'd0;

    dht11_data_receiver #(
        .BIT_THRESHOLD(BIT_THRESHOLD),
        .TIMEOUT      (TIMEOUT),
        .NUM_BITS     (40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dht_in      (dht_in),
        .busy        (busy),
        .data_valid  (data_valid),
        .checksum_err(checksum_err),
        .timeout_err (timeout_err),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .temp_int    (temp_int),
        .temp_dec    (temp_dec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic        exp_busy;
        logic [2:0]  exp_p;
        exp_p = 3'b000;
        if (cyc == ev_cycle) begin
            exp_p = (ev_kind == 0) ? 3'b100 : (ev_kind == 1) ? 3'b010 : 3'b001;
            if (ev_kind == 0) m_data = ev_data;
        end
        exp_busy = (busy_from >= 0) && (cyc >= busy_from) && (ev_cycle < 0 || cyc < ev_cycle);
        check("cycle_outputs",
              {busy, data_valid, checksum_err, timeout_err, hum_int, hum_dec, temp_int, temp_dec},
              {exp_busy, exp_p, m_data});
        if (cyc == ev_cycle) begin
            busy_from = -1;
            ev_cycle  = -1;
        end
        if (data_valid)   dv_seen++;
        if (checksum_err) ce_seen++;
        if (timeout_err)  te_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start();
        start     = 1'b1;
        busy_from = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        busy_from = -1;
        ev_cycle  = -1;
        m_data    = 32'd0;
        rst       = 1'b0;
        dht_in    = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(5);
    endtask

    // wmode: 0 nominal 27/70 us, 1 threshold edge 40/41, 2 random widths.
    task automatic send_frame(input logic [39:0] bits, input int wmode, input int abort_after,
                              input bit poke);
        int          h;
        int          sum;
        logic [39:0] dec;
        dec    = 40'd0;
        dht_in = 1'b1;
        do_start();
        idle($urandom_range(20, 60));
        for (int i = 0; i < 40; i++) begin
            dht_in = 1'b0;
            idle(wmode == 2 ? int'($urandom_range(45, 55)) : 50);
            dht_in = 1'b1;
            case (wmode)
                0:       h = bits[39-i] ? 70 : 27;
                1:       h = bits[39-i] ? 41 : 40;
                default: h = bits[39-i] ? int'($urandom_range(41, 75)) : int'($urandom_range(20, 40));
            endcase
            if (poke && i == 9) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                idle(h - 1);
            end else begin
                idle(h);
            end
            dec = {dec[38:0], (h > BIT_THRESHOLD)};
            if (i == abort_after) begin
                do_reset();
                return;
            end
        end
        dht_in = 1'b0;
        sum = int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8]);
        ev_kind  = ((sum % 256) == int'(dec[7:0])) ? 0 : 1;
        ev_data  = dec[39:8];
        ev_cycle = cyc + 3 + SYNC_LAT;
        idle(50);
        dht_in = 1'b1;
        idle(20);
    endtask

    initial begin
        idle(4);
        rst = 1'b1;
        idle(5);

        send_frame(40'h37_00_18_00_4F, 0, -1, 1'b0);
        check("nominal_hum_int",  36'(hum_int),  36'(55));
        check("nominal_temp_int", 36'(temp_int), 36'(24));
        check("nominal_decs",     36'({hum_dec, temp_dec}), 36'(0));
        check("nominal_dv_count", 36'(dv_seen),  36'(1));

        send_frame(40'h37_00_18_00_50, 0, -1, 1'b0);
        check("badsum_ce_count",  36'(ce_seen),  36'(1));
        check("badsum_dv_count",  36'(dv_seen),  36'(1));
        check("badsum_hold",      36'(hum_int),  36'(55));

        send_frame(40'h01_02_03_04_0A, 1, -1, 1'b0);
        check("edge_bytes", 36'({hum_int, hum_dec, temp_int, temp_dec}), 36'(32'h01020304));

        dht_in = 1'b1;
        do_start();
        ev_kind  = 2;
        ev_cycle = busy_from + TIMEOUT + 1;
        idle(250);
        check("timeout_count", 36'(te_seen), 36'(1));
        check("timeout_hold",  36'(temp_dec), 36'(4));

        send_frame(40'h37_00_18_00_4F, 0, 16, 1'b0);
        check("abort_cleared", 36'({hum_int, hum_dec, temp_int, temp_dec}), 36'(0));
        send_frame(40'h37_00_18_00_4F, 0, -1, 1'b0);
        check("after_abort_hum", 36'(hum_int), 36'(55));

        send_frame(40'h41_05_19_02_61, 0, -1, 1'b1);
        check("poke_bytes", 36'({hum_int, hum_dec, temp_int, temp_dec}), 36'(32'h41051902));
        check("poke_dv_count", 36'(dv_seen), 36'(4));

        for (int k = 0; k < 5; k++) begin
            logic [31:0] d;
            logic [7:0]  cs;
            d  = $urandom;
            cs = d[31:24] + d[23:16] + d[15:8] + d[7:0];
            if ($urandom_range(0, 2) == 0) cs = cs ^ 8'(1 + $urandom_range(0, 254));
            send_frame({d, cs}, 2, -1, 1'b0);
        end

        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        n_bad++;
        $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
